// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared constants and state encoding for the mux scan sequencer
package mux_scan_pkg;
    localparam int NCH     = 8;
    localparam int SEL_W   = 3;
    localparam int DWELL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;
endpackage

// File: rtl/Mux8_1.sv
// rtl/Mux8_1.sv - 8:1 byte mux steered by the sequencer selects
module Mux8_1 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i7,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case ({s2, s1, s0})
            3'd0:    y = i0;
            3'd1:    y = i1;
            3'd2:    y = i2;
            3'd3:    y = i3;
            3'd4:    y = i4;
            3'd5:    y = i5;
            3'd6:    y = i6;
            default: y = i7;
        endcase
    end
endmodule

// File: rtl/mux_next_ch.sv
// rtl/mux_next_ch.sv - finds the lowest enabled channel and the next enabled channel above cur
module mux_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] nxt,
    output logic             has_above,
    output logic [SEL_W-1:0] first
);
    // Walking downward leaves the lowest qualifying bit as the final assignment.
    always_comb begin
        nxt       = '0;
        has_above = 1'b0;
        first     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first = SEL_W'(i);
                if (i > int'(cur)) begin
                    nxt       = SEL_W'(i);
                    has_above = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps mux selects over enabled channels and emits tagged samples
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             stop,
    input  logic [NCH-1:0]   en_mask,
    input  logic [WIDTH-1:0] mux_y,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);

    state_t             state;
    logic [NCH-1:0]     mask;
    logic               cont_q;
    logic               stop_q;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] cnt;
    logic [NCH-1:0]     scan_mask;
    logic [SEL_W-1:0]   nxt;
    logic [SEL_W-1:0]   first;
    logic               has_above;

    // While idle the finder looks at the live enables so start can pick the first channel.
    assign scan_mask = (state == IDLE) ? en_mask : mask;

    mux_next_ch u_next (
        .mask      (scan_mask),
        .cur       (sel),
        .nxt       (nxt),
        .has_above (has_above),
        .first     (first)
    );

    assign s0 = sel[0];
    assign s1 = sel[1];
    assign s2 = sel[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask      <= '0;
            cont_q    <= 1'b0;
            stop_q    <= 1'b0;
            sel       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (en_mask != '0) begin
                            mask   <= en_mask;
                            cont_q <= cont;
                            stop_q <= stop;
                            sel    <= first;
                            cnt    <= DWELL_LOAD;
                            busy   <= 1'b1;
                            state  <= SETTLE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    stop_q <= stop_q | stop;
                    if (cnt == '0) begin
                        out_data  <= mux_y;
                        out_ch    <= sel;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    stop_q <= stop_q | stop;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= DWELL_LOAD;
                        if (has_above) begin
                            sel   <= nxt;
                            state <= SETTLE;
                        end else if (cont_q && !(stop_q || stop)) begin
                            sel   <= first;
                            state <= SETTLE;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - directed and random checks of two sequencers (DWELL 1 and 3)
module tb_mux_scan_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cont = 1'b0;
    logic         stop = 1'b0;
    logic         out_ready = 1'b1;
    logic [7:0]   en_mask = 8'h00;
    logic         s0_w[2], s1_w[2], s2_w[2], ov_w[2], busy_w[2], done_w[2];
    logic [W-1:0] od_w[2], y_w[2];
    logic [2:0]   och_w[2];
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    Mux8_1 #(.WIDTH(W)) u_mux1 (
        .i0(8'h10), .i1(8'h11), .i2(8'h12), .i3(8'h13),
        .i4(8'h14), .i5(8'h15), .i6(8'h16), .i7(8'h17),
        .s0(s0_w[0]), .s1(s1_w[0]), .s2(s2_w[0]), .y(y_w[0])
    );
    mux_scan_sequencer #(.WIDTH(W), .DWELL(1)) u_seq1 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
        .en_mask(en_mask), .mux_y(y_w[0]), .s0(s0_w[0]), .s1(s1_w[0]), .s2(s2_w[0]),
        .out_data(od_w[0]), .out_ch(och_w[0]), .out_valid(ov_w[0]), .out_ready(out_ready),
        .busy(busy_w[0]), .done(done_w[0])
    );
    Mux8_1 #(.WIDTH(W)) u_mux3 (
        .i0(8'h10), .i1(8'h11), .i2(8'h12), .i3(8'h13),
        .i4(8'h14), .i5(8'h15), .i6(8'h16), .i7(8'h17),
        .s0(s0_w[1]), .s1(s1_w[1]), .s2(s2_w[1]), .y(y_w[1])
    );
    mux_scan_sequencer #(.WIDTH(W), .DWELL(3)) u_seq3 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
        .en_mask(en_mask), .mux_y(y_w[1]), .s0(s0_w[1]), .s1(s1_w[1]), .s2(s2_w[1]),
        .out_data(od_w[1]), .out_ch(och_w[1]), .out_valid(ov_w[1]), .out_ready(out_ready),
        .busy(busy_w[1]), .done(done_w[1])
    );

    // Reference model: ordered list of enabled channels, a position in it and a settle countdown.
    int   dwell[2] = '{1, 3};
    logic m_busy[2], m_valid[2], m_done[2], m_cont[2], m_stopf[2];
    int   m_sel[2], m_ch[2], m_data[2], m_wait[2], m_len[2], m_pos[2];
    int   m_lst[2][8];

    logic       p_rstn = 1'b0, p_start = 1'b0, p_cont = 1'b0, p_stop = 1'b0, p_ready = 1'b0;
    logic [7:0] p_mask = 8'h00;
    logic       p_valid[2], p_busy[2];
    int         p_ch[2], p_d[2];

    int nb[2], nd[2], ncap[2], since[2];
    int b_ch[2][64], b_d[2][64], cap_gap[2][64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] pack_dut(input int i);
        return {busy_w[i], done_w[i], ov_w[i], s2_w[i], s1_w[i], s0_w[i], och_w[i], od_w[i]};
    endfunction

    function automatic logic [16:0] pack_model(input int i);
        return {m_busy[i], m_done[i], m_valid[i], 3'(m_sel[i]), 3'(m_ch[i]), 8'(m_data[i])};
    endfunction

    task automatic model_step(input int i);
        m_done[i] = 1'b0;
        if (!p_rstn) begin
            m_busy[i] = 0; m_valid[i] = 0; m_sel[i] = 0; m_ch[i] = 0; m_data[i] = 0;
            m_cont[i] = 0; m_stopf[i] = 0;
        end else if (!m_busy[i]) begin
            if (p_start && p_mask == 8'h00) begin
                m_done[i] = 1'b1;
            end else if (p_start) begin
                m_len[i] = 0;
                for (int c = 0; c < 8; c++)
                    if (p_mask[c]) begin m_lst[i][m_len[i]] = c; m_len[i]++; end
                m_pos[i] = 0; m_sel[i] = m_lst[i][0]; m_wait[i] = dwell[i];
                m_busy[i] = 1; m_cont[i] = p_cont; m_stopf[i] = p_stop;
            end
        end else begin
            m_stopf[i] = m_stopf[i] | p_stop;
            if (m_valid[i]) begin
                if (p_ready) begin
                    m_valid[i] = 0;
                    m_wait[i] = dwell[i];
                    if (m_pos[i] + 1 < m_len[i]) begin
                        m_pos[i]++; m_sel[i] = m_lst[i][m_pos[i]];
                    end else if (m_cont[i] && !m_stopf[i]) begin
                        m_pos[i] = 0; m_sel[i] = m_lst[i][0];
                    end else begin
                        m_busy[i] = 0; m_done[i] = 1;
                    end
                end
            end else begin
                m_wait[i]--;
                if (m_wait[i] == 0) begin
                    m_valid[i] = 1; m_ch[i] = m_sel[i]; m_data[i] = 'h10 + m_sel[i];
                end
            end
        end
    endtask

    // Inputs change just after posedge, so each negedge sees the inputs of the next edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            chk($sformatf("cycle_dwell%0d", dwell[i]), pack_dut(i), pack_model(i));
            if (p_rstn && p_valid[i] && p_ready) begin
                if (nb[i] < 64) begin b_ch[i][nb[i]] = p_ch[i]; b_d[i][nb[i]] = p_d[i]; end
                nb[i]++;
            end
            if (done_w[i]) nd[i]++;
            if ((p_valid[i] && !ov_w[i]) || (!p_busy[i] && busy_w[i])) since[i] = 0;
            else since[i]++;
            if (!p_valid[i] && ov_w[i]) begin
                if (ncap[i] < 64) cap_gap[i][ncap[i]] = since[i];
                ncap[i]++;
            end
            p_valid[i] = ov_w[i]; p_busy[i] = busy_w[i]; p_ch[i] = och_w[i]; p_d[i] = od_w[i];
        end
        p_rstn = rst_n; p_start = start; p_cont = cont; p_stop = stop;
        p_ready = out_ready; p_mask = en_mask;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin nb[i] = 0; nd[i] = 0; ncap[i] = 0; end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy_w[0] || busy_w[1]) && n < 400) begin step(); n++; end
        chk({tag, "_idle_timeout"}, 32'(busy_w[0] || busy_w[1]), 0);
        step();
        step();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!ov_w[0] && n < 50) begin step(); n++; end
        chk({tag, "_valid_timeout"}, 32'(ov_w[0]), 1);
    endtask

    initial begin
        int e2[3] = '{2, 5, 7};
        int e4[4] = '{0, 7, 0, 7};
        int n;
        clear_logs();
        step(); step();
        chk("reset_dwell1", pack_dut(0), 0);
        chk("reset_dwell3", pack_dut(1), 0);
        rst_n = 1'b1;

        // single pass over all channels
        clear_logs();
        en_mask = 8'hFF; cont = 1'b0; out_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        wait_idle("t1");
        chk("t1_beats_dwell1", nb[0], 8);
        chk("t1_beats_dwell3", nb[1], 8);
        for (int k = 0; k < 8; k++) begin
            chk("t1_ch", b_ch[0][k], k);
            chk("t1_data", b_d[0][k], 'h10 + k);
        end
        chk("t1_done", nd[0], 1);
        chk("t1_busy", busy_w[0], 0);

        // sparse mask, capture spacing equals DWELL
        clear_logs();
        en_mask = 8'b1010_0100; start = 1'b1;
        step(); start = 1'b0;
        wait_idle("t2");
        chk("t2_beats", nb[1], 3);
        for (int k = 0; k < 3; k++) begin
            chk("t2_ch", b_ch[1][k], e2[k]);
            chk("t2_gap_dwell3", cap_gap[1][k], 3);
            chk("t2_gap_dwell1", cap_gap[0][k], 1);
        end

        // backpressure on the ch2 beat
        clear_logs();
        en_mask = 8'h0C; out_ready = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        wait_valid("t3");
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold", {ov_w[0], od_w[0], s2_w[0], s1_w[0], s0_w[0]}, {1'b1, 8'h12, 3'd2});
            step();
        end
        out_ready = 1'b1;
        step();
        chk("t3_after_xfer", {ov_w[0], s2_w[0], s1_w[0], s0_w[0]}, {1'b0, 3'd3});
        wait_idle("t3");

        // continuous scan, stop during the third beat
        clear_logs();
        en_mask = 8'h81; cont = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        n = 0;
        while (!(nb[0] == 2 && ov_w[0]) && n < 50) begin step(); n++; end
        chk("t4_third_beat_seen", 32'(nb[0] == 2 && ov_w[0]), 1);
        stop = 1'b1;
        step(); stop = 1'b0;
        wait_idle("t4");
        chk("t4_beats", nb[0], 4);
        for (int k = 0; k < 4; k++) chk("t4_ch", b_ch[0][k], e4[k]);
        chk("t4_done", nd[0], 1);
        cont = 1'b0;

        // empty mask, then start held while busy
        clear_logs();
        en_mask = 8'h00; start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        chk("t5_empty_done", nd[0], 1);
        chk("t5_empty_beats", nb[0] + nb[1], 0);
        chk("t5_empty_busy", busy_w[0], 0);
        clear_logs();
        en_mask = 8'h03; start = 1'b1;
        step(); step(); step();
        start = 1'b0; en_mask = 8'hF0;
        wait_idle("t5");
        chk("t5_busy_beats", nb[0], 2);
        chk("t5_busy_ch0", b_ch[0][0], 0);
        chk("t5_busy_ch1", b_ch[0][1], 1);
        chk("t5_busy_done", nd[0], 1);

        // reset while a beat is held
        clear_logs();
        en_mask = 8'h30; out_ready = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        wait_valid("t6");
        rst_n = 1'b0;
        step(); rst_n = 1'b1;
        chk("t6_reset_dwell1", pack_dut(0), 0);
        chk("t6_reset_dwell3", pack_dut(1), 0);
        out_ready = 1'b1;
        clear_logs();
        start = 1'b1;
        step(); start = 1'b0;
        wait_idle("t6");
        chk("t6_beats", nb[0], 2);
        chk("t6_first_ch", b_ch[0][0], 4);
        chk("t6_second_ch", b_ch[0][1], 5);

        // random traffic against the model
        for (int r = 0; r < 25; r++) begin
            en_mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            cont = 1'($urandom);
            stop = ($urandom_range(0, 7) == 0);
            start = 1'b1;
            for (int c = 0; c < 60; c++) begin
                step();
                start = ($urandom_range(0, 9) == 0);
                stop = ($urandom_range(0, 19) == 0);
                out_ready = ($urandom_range(0, 3) != 0);
                en_mask = 8'($urandom);
                cont = 1'($urandom);
                rst_n = ($urandom_range(0, 99) != 0);
            end
            start = 1'b0; stop = 1'b1; out_ready = 1'b1; rst_n = 1'b1;
            wait_idle("rnd");
            stop = 1'b0;
        end

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
